// File: rtl/fp_iter_sequencer.sv
// fp_iter_sequencer: control FSM for the iterative floating-point mantissa
// datapath. Pulses operand load, steps the datapath a fixed number of times,
// issues normalisation shifts up to a limit, then presents the result with a
// valid/ready handshake.
module fp_iter_sequencer #(
    parameter int STEPS    = 13,
    parameter int NORM_MAX = 12,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             exc,
    input  logic             norm_needed,
    input  logic             result_ready,
    output logic             busy,
    output logic             load_en,
    output logic             step_en,
    output logic [CNT_W-1:0] step_idx,
    output logic             norm_en,
    output logic             result_valid,
    output logic             norm_limit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] LP_NORM_MAX  = CNT_W'(NORM_MAX);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_step_cnt;
    logic [CNT_W-1:0] r_norm_cnt;
    logic             r_norm_limit;
    logic             w_norm_room;
    logic             w_last_step;
    logic             w_norm_en;
    logic             w_hit_limit;

    assign w_last_step = (r_step_cnt == LP_LAST_STEP);
    assign w_norm_room = (r_norm_cnt < LP_NORM_MAX);
    assign w_norm_en   = (r_state == S_NORM) && norm_needed && w_norm_room;
    assign w_hit_limit = (r_state == S_NORM) && norm_needed && !w_norm_room;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only honoured from IDLE or an accepted DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = exc ? S_DONE : S_ITER;
            end
            S_ITER: begin
                if (w_last_step) begin
                    w_next = S_NORM;
                end
            end
            S_NORM: begin
                if (!norm_needed || !w_norm_room) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    w_next = start ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Step counter walks 0..STEPS-1 in ITER and is cleared for every new operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_cnt <= '0;
        end else if (w_next == S_LOAD) begin
            r_step_cnt <= '0;
        end else if (r_state == S_ITER) begin
            r_step_cnt <= w_last_step ? '0 : r_step_cnt + 1'b1;
        end
    end

    // Normalisation shift counter and sticky limit flag, cleared when LOAD is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_norm_cnt   <= '0;
            r_norm_limit <= 1'b0;
        end else if (w_next == S_LOAD) begin
            r_norm_cnt   <= '0;
            r_norm_limit <= 1'b0;
        end else begin
            if (w_norm_en) begin
                r_norm_cnt <= r_norm_cnt + 1'b1;
            end
            if (w_hit_limit) begin
                r_norm_limit <= 1'b1;
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign load_en      = (r_state == S_LOAD);
    assign step_en      = (r_state == S_ITER);
    assign step_idx     = (r_state == S_ITER) ? r_step_cnt : '0;
    assign norm_en      = w_norm_en;
    assign result_valid = (r_state == S_DONE);
    assign norm_limit   = r_norm_limit;

endmodule

// File: tb/tb_fp_iter_sequencer.sv
// tb_fp_iter_sequencer: per-cycle check of every output against an expected
// timeline built from operation parameters (exception flag, number of cycles
// norm_needed stays high, result_ready delay, back-to-back request).
module tb_fp_iter_sequencer;

    localparam int STEPS    = 13;
    localparam int NORM_MAX = 12;
    localparam int CNT_W    = 4;
    localparam int VW       = CNT_W + 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             exc;
    logic             norm_needed;
    logic             result_ready;
    logic             busy;
    logic             load_en;
    logic             step_en;
    logic [CNT_W-1:0] step_idx;
    logic             norm_en;
    logic             result_valid;
    logic             norm_limit;

    int  checksTotal  = 0;
    int  checksPassed = 0;
    int  failCount    = 0;
    bit  prevLimit    = 1'b0;

    fp_iter_sequencer #(.STEPS(STEPS), .NORM_MAX(NORM_MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .exc          (exc),
        .norm_needed  (norm_needed),
        .result_ready (result_ready),
        .busy         (busy),
        .load_en      (load_en),
        .step_en      (step_en),
        .step_idx     (step_idx),
        .norm_en      (norm_en),
        .result_valid (result_valid),
        .norm_limit   (norm_limit)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Pack an expected output set: {busy,load_en,step_en,step_idx,norm_en,result_valid,norm_limit}
    function automatic logic [VW-1:0] makeExp(bit b, bit ld, bit st, int idx, bit ne, bit rv, bit lim);
        logic [CNT_W-1:0] idxV;
        idxV = CNT_W'(idx);
        return {b, ld, st, idxV, ne, rv, lim};
    endfunction

    task automatic applyStimulus(bit s, bit e, bit n, bit r);
        start        = s;
        exc          = e;
        norm_needed  = n;
        result_ready = r;
    endtask

    task automatic checkOutput(string tag, logic [VW-1:0] expV);
        logic [VW-1:0] obs;
        obs = {busy, load_en, step_en, step_idx, norm_en, result_valid, norm_limit};
        checksTotal++;
        assert (obs === expV) checksPassed++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b (busy,ld,st,idx,ne,rv,lim)", tag, obs, expV);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance to just after the next edge
    task automatic cycle(string tag, bit s, bit e, bit n, bit r, logic [VW-1:0] expV);
        applyStimulus(s, e, n, r);
        #1;
        checkOutput(tag, expV);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(int n);
        for (int i = 0; i < n; i++) begin
            cycle($sformatf("idle%0d", i), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                  makeExp(0, 0, 0, 0, 0, 0, prevLimit));
        end
    endtask

    task automatic idleStart();
        cycle("idleStart", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
              makeExp(0, 0, 0, 0, 0, 0, prevLimit));
    endtask

    // Full operation starting in its LOAD cycle; ends after the accepting DONE cycle
    task automatic runOp(string name, bit opExc, int normLen, int waitCycles, bit b2bNext);
        int  k;
        bit  lim;
        cycle($sformatf("%s.load", name), 1'($urandom), opExc, 1'($urandom), 1'($urandom),
              makeExp(1, 1, 0, 0, 0, 0, 0));
        lim = 1'b0;
        if (!opExc) begin
            for (int i = 0; i < STEPS; i++) begin
                cycle($sformatf("%s.iter%0d", name, i), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), makeExp(1, 0, 1, i, 0, 0, 0));
            end
            k   = (normLen < NORM_MAX) ? normLen : NORM_MAX;
            lim = (normLen > NORM_MAX);
            for (int j = 0; j <= k; j++) begin
                cycle($sformatf("%s.norm%0d", name, j), 1'($urandom), 1'($urandom), 1'(j < normLen),
                      1'($urandom), makeExp(1, 0, 0, 0, (j < k), 0, 0));
            end
        end
        for (int w = 0; w < waitCycles; w++) begin
            cycle($sformatf("%s.wait%0d", name, w), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                  makeExp(1, 0, 0, 0, 0, 1, lim));
        end
        cycle($sformatf("%s.accept", name), b2bNext, 1'($urandom), 1'($urandom), 1'b1,
              makeExp(1, 0, 0, 0, 0, 1, lim));
        prevLimit = lim;
    endtask

    initial begin
        int  nOps;
        bit  opExc;
        int  normLen;
        int  waitC;
        bit  b2b;

        // Reset state
        applyStimulus(0, 0, 0, 0);
        rst = 1'b1;
        #1;
        checkOutput("reset", makeExp(0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(2);

        // Basic operation, no normalisation needed
        $display("[TB] directed: basic operation");
        idleStart();
        runOp("basic", 0, 0, 0, 0);
        idleCycles(1);

        // Three normalisation shifts
        $display("[TB] directed: three shifts");
        idleStart();
        runOp("norm3", 0, 3, 0, 0);
        idleCycles(1);

        // Shift limit reached, then next LOAD clears norm_limit
        $display("[TB] directed: shift limit");
        idleStart();
        runOp("limit", 0, 40, 0, 0);
        idleCycles(2);
        idleStart();
        runOp("afterLimit", 0, 12, 0, 0);
        idleCycles(1);

        // Exception path
        $display("[TB] directed: exception");
        idleStart();
        runOp("exc", 1, 0, 0, 0);
        idleCycles(1);

        // Held result with start toggling, then back-to-back
        $display("[TB] directed: hold and back-to-back");
        idleStart();
        runOp("hold", 0, 2, 5, 1);
        runOp("b2b", 0, 1, 0, 0);
        idleCycles(1);

        // Reset in ITER at step_idx 6
        $display("[TB] directed: reset mid-operation");
        idleStart();
        cycle("abort.load", 0, 0, 0, 0, makeExp(1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            cycle($sformatf("abort.iter%0d", i), 0, 0, 0, 0, makeExp(1, 0, 1, i, 0, 0, 0));
        end
        applyStimulus(0, 0, 0, 0);
        #1;
        checkOutput("abort.iter6", makeExp(1, 0, 1, 6, 0, 0, 0));
        rst = 1'b1;
        #1;
        checkOutput("abort.reset", makeExp(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        checkOutput("abort.held", makeExp(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        prevLimit = 1'b0;
        idleCycles(1);
        idleStart();
        runOp("postReset", 0, 0, 0, 0);
        idleCycles(1);

        // Randomised operations
        $display("[TB] random operations");
        idleStart();
        nOps = 40;
        for (int n = 0; n < nOps; n++) begin
            opExc   = ($urandom_range(0, 3) == 0);
            normLen = $urandom_range(0, 15);
            waitC   = $urandom_range(0, 3);
            b2b     = (n == nOps - 1) ? 1'b0 : 1'($urandom);
            runOp($sformatf("rnd%0d", n), opExc, normLen, waitC, b2b);
            if (!b2b && n != nOps - 1) begin
                idleCycles($urandom_range(0, 2));
                idleStart();
            end
        end
        idleCycles(1);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
